// File: rtl/gpgpu_obi_pkg.sv
// Constants shared by the OBI initiators in the memory subsystem.
package gpgpu_obi_pkg;

    localparam logic [3:0]  OBI_BE_FULL    = 4'hF;
    localparam int unsigned OBI_WORD_BYTES = 4;

    // Byte address of word 'idx' past 'base'; wraps modulo 2^32 like the bus itself.
    function automatic logic [31:0] obi_word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx * OBI_WORD_BYTES);
    endfunction

endpackage

// File: rtl/obi_req_if.sv
// OBI address/request channel: initiator drives the request, target answers with gnt.
interface obi_req_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    modport master (output req, addr, we, be, wdata, input gnt);
    modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

// File: rtl/obi_rsp_if.sv
// OBI response channel; the 'slave' modport is the receiving (initiator) side.
interface obi_rsp_if;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output rvalid, rdata);
    modport slave  (input rvalid, rdata);
endinterface

// File: rtl/obi_copy_master.sv
// OBI block-copy initiator: reads a word, writes it to the destination, one transaction in flight.
module obi_copy_master
    import gpgpu_obi_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    obi_req_if.master        req,
    obi_rsp_if.slave         rsp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             misaligned;

    assign cnt_inc    = cnt_q + LEN_W'(1);
    assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

    // All bus fields are registered; wdata doubles as the data register while the write is pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            req.req   <= 1'b0;
            req.addr  <= '0;
            req.we    <= 1'b0;
            req.be    <= '0;
            req.wdata <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (misaligned) begin
                            err_o <= 1'b1;
                        end else if (len_i == '0) begin
                            busy_o  <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            src_q    <= src_addr_i;
                            dst_q    <= dst_addr_i;
                            len_q    <= len_i;
                            cnt_q    <= '0;
                            busy_o   <= 1'b1;
                            req.req  <= 1'b1;
                            req.we   <= 1'b0;
                            req.be   <= OBI_BE_FULL;
                            req.addr <= src_addr_i;
                            state_q  <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (req.gnt) begin
                        req.req  <= 1'b0;
                        req.be   <= '0;
                        req.addr <= '0;
                        state_q  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rsp.rvalid) begin
                        req.req   <= 1'b1;
                        req.we    <= 1'b1;
                        req.be    <= OBI_BE_FULL;
                        req.addr  <= obi_word_addr(dst_q, 32'(cnt_q));
                        req.wdata <= rsp.rdata;
                        state_q   <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (req.gnt) begin
                        req.req   <= 1'b0;
                        req.we    <= 1'b0;
                        req.be    <= '0;
                        req.addr  <= '0;
                        req.wdata <= '0;
                        state_q   <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (rsp.rvalid) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            req.req  <= 1'b1;
                            req.we   <= 1'b0;
                            req.be   <= OBI_BE_FULL;
                            req.addr <= obi_word_addr(src_q, 32'(cnt_inc));
                            state_q  <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_copy_master.sv
// Bench for obi_copy_master: behavioural SRAM target with tunable gnt/rvalid latency plus a scoreboard.
module tb_obi_copy_master;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic is_err;
        int   cyc;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    obi_req_if bus_req ();
    obi_rsp_if bus_rsp ();

    obi_copy_master #(.LEN_W(16)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .req        (bus_req),
        .rsp        (bus_rsp)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [logic [31:0]];
    txn_t        exp_bus [$];
    ev_t         exp_ev  [$];
    logic [31:0] rd_log  [$];

    int gmax     = 0;
    int rmax     = 0;
    bit stray_rv = 1'b0;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Target model: gnt after 0..gmax wait cycles, rvalid 1..rmax+1 cycles after gnt.
    initial begin
        bit          hs = 1'b0;
        bit          pend = 1'b0;
        int          gwait = -1;
        int          rwait = 0;
        logic        hs_we = 1'b0;
        logic        p_we = 1'b0;
        logic [31:0] hs_addr = '0;
        logic [31:0] hs_wdata = '0;
        logic [31:0] p_addr = '0;
        bus_req.gnt    = 1'b0;
        bus_rsp.rvalid = 1'b0;
        bus_rsp.rdata  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                hs = 1'b0;
                pend = 1'b0;
                gwait = -1;
                bus_req.gnt    = 1'b0;
                bus_rsp.rvalid = 1'b0;
                bus_rsp.rdata  = '0;
                continue;
            end
            if (hs) begin
                pend  = 1'b1;
                p_we  = hs_we;
                p_addr = hs_addr;
                rwait = $urandom_range(rmax, 0);
                if (hs_we) mem[hs_addr] = hs_wdata;
            end
            hs = 1'b0;
            bus_req.gnt    = 1'b0;
            bus_rsp.rvalid = 1'b0;
            bus_rsp.rdata  = '0;
            if (pend) begin
                if (rwait == 0) begin
                    bus_rsp.rvalid = 1'b1;
                    bus_rsp.rdata  = p_we ? 32'hDEAD_BEEF : memRead(p_addr);
                    pend = 1'b0;
                end else begin
                    rwait--;
                end
            end else if (stray_rv) begin
                bus_rsp.rvalid = 1'b1;
                bus_rsp.rdata  = 32'hBAD0_BAD0;
            end
            if (bus_req.req) begin
                if (gwait < 0) gwait = $urandom_range(gmax, 0);
                if (gwait == 0) begin
                    bus_req.gnt = 1'b1;
                    hs       = 1'b1;
                    hs_we    = bus_req.we;
                    hs_addr  = bus_req.addr;
                    hs_wdata = bus_req.wdata;
                    gwait    = -1;
                end else begin
                    gwait--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and every done/err pulse.
    int          outst = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [4:0]  prev_ctl;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            outst = 0;
            prev_wait = 1'b0;
        end else begin
            if (bus_rsp.rvalid && outst > 0) outst--;
            if (bus_req.req) checkOutput("one_outstanding", outst, 0);
            if (prev_wait && bus_req.req) begin
                checkOutput("stable_addr", bus_req.addr, prev_addr);
                checkOutput("stable_wdata", bus_req.wdata, prev_wdata);
                checkOutput("stable_we_be", {27'b0, bus_req.we, bus_req.be}, {27'b0, prev_ctl});
            end
            if (bus_req.req && bus_req.gnt) begin
                outst++;
                if (!bus_req.we) rd_log.push_back(bus_req.addr);
                if (exp_bus.size() == 0) begin
                    failNow("unexpected_bus_txn");
                end else begin
                    txn_t e;
                    e = exp_bus.pop_front();
                    checkOutput("txn_we", bus_req.we, e.we);
                    checkOutput("txn_addr", bus_req.addr, e.addr);
                    checkOutput("txn_wdata", bus_req.wdata, e.wdata);
                    checkOutput("txn_be", bus_req.be, 4'hF);
                end
            end
            prev_wait  = bus_req.req && !bus_req.gnt;
            prev_addr  = bus_req.addr;
            prev_wdata = bus_req.wdata;
            prev_ctl   = {bus_req.we, bus_req.be};
            if (done_o || err_o) begin
                if (exp_ev.size() == 0) begin
                    failNow("unexpected_done_err");
                end else begin
                    ev_t v;
                    v = exp_ev.pop_front();
                    checkOutput("event_err", err_o, v.is_err);
                    checkOutput("event_done", done_o, !v.is_err);
                    if (v.cyc >= 0) checkOutput("event_cycle", cyc, v.cyc);
                end
            end
        end
    end

    task automatic pushExpected(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] n,
                                input logic [31:0] base, input logic [31:0] step, input int t);
        if (src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
            exp_ev.push_back('{1'b1, (t < 0) ? -1 : t + 1});
        end else if (n == 0) begin
            exp_ev.push_back('{1'b0, (t < 0) ? -1 : t + 1});
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                mem[src + 32'(i * 4)] = base + step * 32'(i);
                exp_bus.push_back('{1'b0, src + 32'(i * 4), 32'h0});
                exp_bus.push_back('{1'b1, dst + 32'(i * 4), base + step * 32'(i)});
            end
            exp_ev.push_back('{1'b0, (t < 0) ? -1 : t + 4 * int'(n) + 1});
        end
    endtask

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] n,
                                 input logic [31:0] base, input logic [31:0] step, input bit timed,
                                 output int t);
        @(negedge clk_i);
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start_i  = 1'b1;
        t        = cyc;
        pushExpected(src, dst, n, base, step, timed ? t : -1);
        @(negedge clk_i);
        start_i  = 1'b0;
    endtask

    task automatic waitDone(input int maxc);
        int k = 0;
        while ((exp_ev.size() != 0 || exp_bus.size() != 0) && k < maxc) begin
            @(negedge clk_i);
            k++;
        end
        if (exp_ev.size() != 0 || exp_bus.size() != 0) failNow("timeout_waiting_for_done");
        @(negedge clk_i);
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk_i);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req"}, bus_req.req, 0);
        checkOutput({tag, "_addr"}, bus_req.addr, 0);
        checkOutput({tag, "_we"}, bus_req.we, 0);
        checkOutput({tag, "_be"}, bus_req.be, 0);
        checkOutput({tag, "_wdata"}, bus_req.wdata, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        int t;
        int bc;
        int k;
        bit saw_req;
        bit saw_busy;
        logic [31:0] wrap_exp [4];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        repeat (3) @(negedge clk_i);
        checkIdleOutputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] zero-wait copy of 4 words");
        applyStimulus(32'h100, 32'h200, 16'd4, 32'hA0, 32'h1, 1'b1, t);
        bc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy_o) bc++;
            @(negedge clk_i);
        end
        checkOutput("busy_cycles", bc, 17);
        waitDone(100);
        for (int i = 0; i < 4; i++)
            checkOutput("copy1_dst", memRead(32'h200 + 32'(i * 4)), 32'hA0 + 32'(i));

        $display("[TB] random-latency copy of 16 words");
        gmax = 3;
        rmax = 3;
        applyStimulus(32'h1000, 32'h2000, 16'd16, 32'h1111_0000, 32'h0101, 1'b0, t);
        waitDone(16 * 12 + 50);
        for (int i = 0; i < 16; i++)
            checkOutput("copy2_dst", memRead(32'h2000 + 32'(i * 4)), 32'h1111_0000 + 32'h0101 * 32'(i));
        gmax = 0;
        rmax = 0;

        $display("[TB] rejected starts and zero length");
        applyStimulus(32'h102, 32'h200, 16'd4, 32'h0, 32'h0, 1'b1, t);
        saw_req = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_req  |= bus_req.req;
            saw_busy |= busy_o;
            @(negedge clk_i);
        end
        checkOutput("err_src_no_req", saw_req, 0);
        checkOutput("err_src_no_busy", saw_busy, 0);
        waitDone(10);
        applyStimulus(32'h100, 32'h203, 16'd4, 32'h0, 32'h0, 1'b1, t);
        checkOutput("err_dst_no_req", bus_req.req, 0);
        waitDone(10);
        applyStimulus(32'h100, 32'h200, 16'd0, 32'h0, 32'h0, 1'b1, t);
        checkOutput("len0_busy_in_done", busy_o, 1);
        checkOutput("len0_no_req", bus_req.req, 0);
        waitDone(10);
        checkOutput("len0_busy_after", busy_o, 0);

        $display("[TB] address wrap");
        rd_log.delete();
        applyStimulus(32'hFFFF_FFF8, 32'h300, 16'd4, 32'hC0, 32'h1, 1'b1, t);
        waitDone(60);
        checkOutput("wrap_reads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            checkOutput("wrap_rd_addr", rd_log[i], wrap_exp[i]);
        for (int i = 0; i < 4; i++)
            checkOutput("wrap_dst", memRead(32'h300 + 32'(i * 4)), 32'hC0 + 32'(i));

        $display("[TB] reset during write of word 2");
        applyStimulus(32'h400, 32'h500, 16'd8, 32'hD0, 32'h1, 1'b1, t);
        k = 0;
        do begin
            @(posedge clk_i);
            #2;
            k++;
        end while (cyc != t + 11 && k < 50);
        checkOutput("pre_rst_req", bus_req.req, 1);
        checkOutput("pre_rst_we", bus_req.we, 1);
        checkOutput("pre_rst_addr", bus_req.addr, 32'h508);
        checkOutput("pre_rst_wdata", bus_req.wdata, 32'hD2);
        rst_ni = 1'b0;
        #1;
        checkOutput("async_rst_req", bus_req.req, 0);
        exp_bus.delete();
        exp_ev.delete();
        repeat (2) @(negedge clk_i);
        checkIdleOutputs("in_rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkIdleOutputs("post_rst");
        checkOutput("rst_kept_w0", memRead(32'h500), 32'hD0);
        checkOutput("rst_kept_w1", memRead(32'h504), 32'hD1);
        checkOutput("rst_abandoned_w2", memRead(32'h508), 32'h0);
        applyStimulus(32'h600, 32'h700, 16'd1, 32'hE0, 32'h1, 1'b1, t);
        waitDone(30);
        checkOutput("post_rst_copy", memRead(32'h700), 32'hE0);

        $display("[TB] start held high across completion");
        @(negedge clk_i);
        src_addr = 32'h800;
        dst_addr = 32'h900;
        len      = 16'd2;
        start_i  = 1'b1;
        t        = cyc;
        pushExpected(32'h800, 32'h900, 16'd2, 32'hF0, 32'h1, t);
        pushExpected(32'h800, 32'h900, 16'd2, 32'hF0, 32'h1, t + 10);
        waitCycle(t + 10);
        checkOutput("held_idle_busy", busy_o, 0);
        checkOutput("held_idle_req", bus_req.req, 0);
        waitCycle(t + 11);
        checkOutput("held_restart_req", bus_req.req, 1);
        checkOutput("held_restart_addr", bus_req.addr, 32'h800);
        waitCycle(t + 19);
        start_i = 1'b0;
        @(negedge clk_i);
        checkOutput("held_end_busy", busy_o, 0);
        waitDone(20);
        checkOutput("held_dst0", memRead(32'h900), 32'hF0);
        checkOutput("held_dst1", memRead(32'h904), 32'hF1);

        $display("[TB] stray rvalid in idle");
        stray_rv = 1'b1;
        repeat (3) @(negedge clk_i);
        stray_rv = 1'b0;
        saw_req = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_req  |= bus_req.req;
            saw_busy |= busy_o | done_o | err_o;
            @(negedge clk_i);
        end
        checkOutput("stray_no_req", saw_req, 0);
        checkOutput("stray_no_activity", saw_busy, 0);

        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
